id_stage: RTL

//  RV64I instruction-decode stage; sits directly upstream of the `register` file and downstream of fetch.

---
 rtl/id_stage_pkg.sv | 64 ++++++
 rtl/id_stage_if.sv | 36 +++
 rtl/id_stage_imm_gen.sv | 24 ++
 rtl/id_stage.sv | 111 +++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared RV64I decode definitions: widths, base opcodes, immediate formats and
// the ID/EX payload layout.
package id_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_we;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } idex_t;

    // FENCE and SYSTEM carry their fields in the I-type layout.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:  return IMM_I;
            OPC_STORE:                 return IMM_S;
            OPC_BRANCH:                return IMM_B;
            OPC_LUI, OPC_AUIPC:        return IMM_U;
            OPC_JAL:                   return IMM_J;
            default:                   return IMM_NONE;
        endcase
    endfunction

    function automatic logic opc_legal(input logic [6:0] opc);
        return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                           OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM,
                           OPC_OP_IMM_32, OPC_OP_32, OPC_SYSTEM};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle. The slave modport is
// the decode stage's view; master is the surrounding pipeline's view.
interface id_stage_if;
    import id_stage_pkg::*;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic            ex_rd_we;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic            ex_illegal;

    modport master (
        output if_valid, if_pc, if_instr, ex_ready,
        input  if_ready, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_rd_we, ex_opcode, ex_funct3, ex_funct7, ex_illegal
    );

    modport slave (
        input  if_valid, if_pc, if_instr, ex_ready,
        output if_ready, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_rd_we, ex_opcode, ex_funct3, ex_funct7, ex_illegal
    );

endinterface

// File: rtl/id_stage_imm_gen.sv
// Combinational immediate extraction for all RV64I formats, sign-extended from
// instr[31]; opcodes without an immediate yield zero.
module id_stage_imm_gen
    import id_stage_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_fmt(instr[6:0]))
            IMM_I: imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_U: imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J: imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV64I decode stage: drives regfile read addresses, tracks in-flight
// destinations in a busy-bit scoreboard and loads a single ID/EX register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    id_stage_if.slave       bus,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] out1,
    input  logic [XLEN-1:0] out2,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic            flush
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            legal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            rd_we;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] imm;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    idex_t           idex_d;
    idex_t           idex_p1;
    logic            vld_p1;

    assign opcode = bus.if_instr[6:0];
    assign rd     = bus.if_instr[11:7];
    assign rs1    = bus.if_instr[19:15];
    assign rs2    = bus.if_instr[24:20];

    assign legal    = opc_legal(opcode);
    assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign uses_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP, OPC_OP_32};
    assign rd_we    = legal && !(opcode inside {OPC_BRANCH, OPC_STORE, OPC_MISC_MEM})
                      && (rd != 5'd0);

    // Scoreboard is read before this cycle's writeback clears it: no bypass.
    assign hazard = (uses_rs1 && busy_q[rs1]) || (uses_rs2 && busy_q[rs2])
                    || (rd_we && busy_q[rd]);

    assign bus.if_ready = (!vld_p1 || bus.ex_ready) && !hazard && !flush && !rst;
    assign accept       = bus.if_valid && bus.if_ready;

    id_stage_imm_gen u_imm_gen (
        .instr (bus.if_instr),
        .imm   (imm)
    );

    always_comb begin
        idex_d         = '0;
        idex_d.pc      = bus.if_pc;
        idex_d.op1     = (rs1 == 5'd0) ? '0 : out1;
        idex_d.op2     = (rs2 == 5'd0) ? '0 : out2;
        idex_d.imm     = imm;
        idex_d.rd      = rd;
        idex_d.rd_we   = rd_we;
        idex_d.opcode  = opcode;
        idex_d.funct3  = bus.if_instr[14:12];
        idex_d.funct7  = bus.if_instr[31:25];
        idex_d.illegal = !legal;
    end

    // Clears first so a same-index set in the same cycle takes priority.
    always_comb begin
        busy_d = busy_q;
        if (wb_we && (wb_rd != 5'd0)) busy_d[wb_rd] = 1'b0;
        if (flush && vld_p1 && idex_p1.rd_we) busy_d[idex_p1.rd] = 1'b0;
        if (accept && rd_we) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // ID/EX boundary (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            idex_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            idex_p1 <= idex_d;
        end else if (bus.ex_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.ex_valid   = vld_p1;
    assign bus.ex_pc      = idex_p1.pc;
    assign bus.ex_op1     = idex_p1.op1;
    assign bus.ex_op2     = idex_p1.op2;
    assign bus.ex_imm     = idex_p1.imm;
    assign bus.ex_rd      = idex_p1.rd;
    assign bus.ex_rd_we   = idex_p1.rd_we;
    assign bus.ex_opcode  = idex_p1.opcode;
    assign bus.ex_funct3  = idex_p1.funct3;
    assign bus.ex_funct7  = idex_p1.funct7;
    assign bus.ex_illegal = idex_p1.illegal;

endmodule
